// File: rtl/drm_ctrl_stream_endpoint.sv
// Controller-side endpoint of the DRM AXI4-Stream link.
// The host loads a command frame into the TX buffer and starts a transaction.
// The block streams the frame out on drm_to_uip and captures the response
// from uip_to_drm into the RX buffer. It then reports done with an error code.
module drm_ctrl_stream_endpoint #(
  parameter int DEPTH          = 16,
  parameter int AW             = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          drm_aclk,
  input  logic          drm_arstn,
  input  logic          cmd_wr_en,
  input  logic [AW-1:0] cmd_wr_addr,
  input  logic [31:0]   cmd_wr_data,
  input  logic [AW:0]   cmd_len,
  input  logic          cmd_start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err_code,
  output logic [AW:0]   rsp_len,
  input  logic [AW-1:0] rsp_rd_addr,
  output logic [31:0]   rsp_rd_data,
  input  logic          drm_to_uip_tready,
  output logic          drm_to_uip_tvalid,
  output logic [31:0]   drm_to_uip_tdata,
  output logic          drm_to_uip_tlast,
  output logic          uip_to_drm_tready,
  input  logic          uip_to_drm_tvalid,
  input  logic [31:0]   uip_to_drm_tdata,
  input  logic          uip_to_drm_tlast
);

  // Idle counter only needs to hold 0..TIMEOUT_CYCLES-1.
  localparam int              TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   IDLE_MAX    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]     DEPTH_W     = (AW+1)'(DEPTH);
  localparam logic [1:0]      ERR_OK      = 2'd0;
  localparam logic [1:0]      ERR_TIMEOUT = 2'd1;
  localparam logic [1:0]      ERR_OVF     = 2'd2;
  localparam logic [1:0]      ERR_LEN     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];

  state_t        state_r, state_s;
  logic [AW:0]   len_r, len_s;
  logic [AW-1:0] idx_r, idx_s, idx_inc_s;
  logic [AW:0]   cnt_r, cnt_s;
  logic          ovf_r, ovf_s;
  logic [TW-1:0] idle_r, idle_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [1:0]    err_r, err_s;
  logic [AW:0]   rsp_len_r, rsp_len_s;
  logic          tx_valid_r, tx_valid_s;
  logic [31:0]   tx_data_r, tx_data_s;
  logic          tx_last_r, tx_last_s;
  logic          rx_ready_r, rx_ready_s;
  logic [31:0]   rd_data_r;
  logic          rx_wr_en_s;
  logic          tx_wr_en_s;
  logic          tx_hs_s;
  logic          rx_beat_s;
  logic          len_ok_s;

  assign busy              = busy_r;
  assign done              = done_r;
  assign err_code          = err_r;
  assign rsp_len           = rsp_len_r;
  assign rsp_rd_data       = rd_data_r;
  assign drm_to_uip_tvalid = tx_valid_r;
  assign drm_to_uip_tdata  = tx_data_r;
  assign drm_to_uip_tlast  = tx_last_r;
  assign uip_to_drm_tready = rx_ready_r;

  assign tx_wr_en_s = cmd_wr_en & (state_r == ST_IDLE);
  assign tx_hs_s    = tx_valid_r & drm_to_uip_tready;
  assign rx_beat_s  = uip_to_drm_tvalid & rx_ready_r;
  assign len_ok_s   = (cmd_len != (AW+1)'(0)) && (cmd_len <= DEPTH_W);
  assign idx_inc_s  = idx_r + AW'(1);

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    ovf_s      = ovf_r;
    idle_s     = idle_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    err_s      = err_r;
    rsp_len_s  = rsp_len_r;
    tx_valid_s = tx_valid_r;
    tx_data_s  = tx_data_r;
    tx_last_s  = tx_last_r;
    rx_ready_s = rx_ready_r;
    rx_wr_en_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (cmd_start) begin
          busy_s    = 1'b1;
          rsp_len_s = (AW+1)'(0);
          if (len_ok_s) begin
            state_s    = ST_SEND;
            len_s      = cmd_len;
            idx_s      = AW'(0);
            cnt_s      = (AW+1)'(0);
            ovf_s      = 1'b0;
            idle_s     = TW'(0);
            err_s      = ERR_OK;
            tx_valid_s = 1'b1;
            tx_data_s  = tx_mem[0];
            tx_last_s  = (cmd_len == (AW+1)'(1));
          end else begin
            // Bad length: report straight away, never touch the bus.
            state_s = ST_DONE;
            done_s  = 1'b1;
            err_s   = ERR_LEN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (tx_hs_s) begin
          if (tx_last_r) begin
            state_s    = ST_RECV;
            tx_valid_s = 1'b0;
            tx_last_s  = 1'b0;
            rx_ready_s = 1'b1;
            idle_s     = TW'(0);
          end else begin
            idx_s     = idx_inc_s;
            tx_data_s = tx_mem[idx_inc_s];
            tx_last_s = ({1'b0, idx_inc_s} == (len_r - (AW+1)'(1)));
          end
        end else begin
          // Stalled: hold the beat on the bus.
          state_s = ST_SEND;
        end
      end

      ST_RECV: begin
        if (rx_beat_s) begin
          idle_s = TW'(0);
          if (cnt_r < DEPTH_W) begin
            rx_wr_en_s = 1'b1;
            cnt_s      = cnt_r + (AW+1)'(1);
          end else begin
            // Buffer full: drop the word but keep draining the frame.
            ovf_s = 1'b1;
          end
          if (uip_to_drm_tlast) begin
            state_s    = ST_DONE;
            done_s     = 1'b1;
            rx_ready_s = 1'b0;
            rsp_len_s  = cnt_s;
            err_s      = ovf_s ? ERR_OVF : ERR_OK;
          end else begin
            state_s = ST_RECV;
          end
        end else begin
          if (idle_r == IDLE_MAX) begin
            state_s    = ST_DONE;
            done_s     = 1'b1;
            rx_ready_s = 1'b0;
            rsp_len_s  = cnt_r;
            err_s      = ERR_TIMEOUT;
          end else begin
            idle_s = idle_r + TW'(1);
          end
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s    = ST_IDLE;
        busy_s     = 1'b0;
        tx_valid_s = 1'b0;
        tx_last_s  = 1'b0;
        rx_ready_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge drm_aclk or negedge drm_arstn) begin
    if (!drm_arstn) begin
      state_r    <= ST_IDLE;
      len_r      <= (AW+1)'(0);
      idx_r      <= AW'(0);
      cnt_r      <= (AW+1)'(0);
      ovf_r      <= 1'b0;
      idle_r     <= TW'(0);
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 2'd0;
      rsp_len_r  <= (AW+1)'(0);
      tx_valid_r <= 1'b0;
      tx_data_r  <= 32'd0;
      tx_last_r  <= 1'b0;
      rx_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      ovf_r      <= ovf_s;
      idle_r     <= idle_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      rsp_len_r  <= rsp_len_s;
      tx_valid_r <= tx_valid_s;
      tx_data_r  <= tx_data_s;
      tx_last_r  <= tx_last_s;
      rx_ready_r <= rx_ready_s;
    end
  end

  // Buffer storage; contents survive reset.
  always_ff @(posedge drm_aclk) begin
    if (tx_wr_en_s) begin
      tx_mem[cmd_wr_addr] <= cmd_wr_data;
    end
    if (rx_wr_en_s) begin
      rx_mem[cnt_r[AW-1:0]] <= uip_to_drm_tdata;
    end
  end

  // Registered RX read port; a same-cycle write is seen on the next read.
  always_ff @(posedge drm_aclk or negedge drm_arstn) begin
    if (!drm_arstn) begin
      rd_data_r <= 32'd0;
    end else begin
      rd_data_r <= rx_mem[rsp_rd_addr];
    end
  end

endmodule

// File: doc/drm_ctrl_stream_endpoint.md
Name: drm_ctrl_stream_endpoint

Overview:
Controller-side endpoint of the DRM AXI4-Stream link. It is the counterpart that drives the activator's drm_to_uip bus and consumes its uip_to_drm bus. A local host loads a command frame into a TX buffer and starts a transaction. The block transmits the frame, then captures the response frame into an RX buffer and reports completion or an error (timeout, overflow, bad length). Used in DRM-less simulation benches and in the self-test design in place of the full DRM controller.

Parameters:
DEPTH, 16, words in each of the TX and RX buffers; power of two, at least 2.
AW, $clog2(DEPTH), buffer address width (derived; do not override).
TIMEOUT_CYCLES, 4096, idle cycles allowed in receive before abort; at least 1.

Ports:
drm_aclk  in  1  single clock for all logic
drm_arstn  in  1  reset, asynchronous assert, active-low
cmd_wr_en  in  1  write cmd_wr_data to TX buffer at cmd_wr_addr (ignored while busy)
cmd_wr_addr  in  AW  TX buffer write address
cmd_wr_data  in  32  TX buffer write data
cmd_len  in  AW+1  frame length in words, sampled on accepted cmd_start
cmd_start  in  1  start transaction (ignored while busy)
busy  out  1  high from accepted start until the done cycle inclusive
done  out  1  single-cycle completion pulse
err_code  out  2  0 ok, 1 timeout, 2 rsp overflow, 3 bad cmd_len; valid from done, held until next start
rsp_len  out  AW+1  response words stored (saturates at DEPTH); held like err_code
rsp_rd_addr  in  AW  RX buffer read address
rsp_rd_data  out  32  RX buffer data, registered, 1-cycle read latency
drm_to_uip_tready  in  1  sink ready
drm_to_uip_tvalid  out  1  TX beat valid
drm_to_uip_tdata  out  32  TX beat data
drm_to_uip_tlast  out  1  last TX beat
uip_to_drm_tready  out  1  RX ready
uip_to_drm_tvalid  in  1  RX beat valid
uip_to_drm_tdata  in  32  RX beat data
uip_to_drm_tlast  in  1  last RX beat

Behaviour:
- Reset (async, drm_arstn=0): FSM goes to IDLE. busy, done, tvalid, tlast and uip_to_drm_tready are 0. tdata, err_code, rsp_len and rsp_rd_data are 0. Buffer contents are not reset.
- Reset asserted mid-transaction: abort immediately, no done pulse. Any partial frame on the bus is abandoned.
- FSM states: IDLE, SEND, RECV, DONE.
- IDLE, cmd_start=1 with cmd_len in 1..DEPTH:
  - Latch cmd_len; clear err_code and rsp_len.
  - Go to SEND next cycle with busy=1.
- IDLE, cmd_start=1 with cmd_len=0 or cmd_len>DEPTH: go to DONE with err_code=3; no bus activity.
- SEND:
  - tvalid=1, tdata=txbuf[idx], tlast=(idx==len-1). idx starts at 0.
  - tdata/tlast stay stable while tvalid & !tready.
  - Advance idx on tvalid&tready.
  - On the last handshake go to RECV; tvalid falls the next cycle.
  - No timeout in SEND.
- RECV:
  - uip_to_drm_tready=1. Each tvalid&tready beat writes rxbuf[cnt] when cnt<DEPTH and increments cnt.
  - A beat arriving with cnt==DEPTH is dropped, sets an overflow flag, and draining continues.
  - A beat with tlast → DONE. rsp_len = min(cnt after beat, DEPTH). err_code = 2 if overflow, else 0.
  - Idle counter resets on every beat and increments on every non-beat cycle.
  - When the counter reaches TIMEOUT_CYCLES → DONE with err_code=1 and tready drops. rsp_len = words stored so far.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- cmd_start during busy (including the DONE cycle) is ignored.
- cmd_wr_en during busy is ignored; TX buffer is stable during SEND.
- IDLE: uip_to_drm_tready=0; stray RX beats are not accepted.
- RX buffer read port is always active and returns the buffer content one cycle after the address. A read and write to the same address in the same cycle returns the old data.
- Latency from accepted cmd_start to first tvalid: 1 cycle.
- Latency from RX tlast beat to done: 1 cycle.

Test Plan:
- Load 4 words 0xA0..0xA3, cmd_len=4, sink always ready → 4 beats, tlast on 0xA3. Respond with 3 words 0xB0..0xB2, last beat tlast → done, err=0, rsp_len=3; rsp_rd_addr 0..2 returns 0xB0..0xB2 with 1-cycle latency.
- Same frame with drm_to_uip_tready toggling 1,0,0,1… → data and tlast held stable across stalls, exactly 4 handshakes, order preserved.
- DEPTH=16, response of 18 beats → stored words 0..15, rsp_len=16, err=2; done 1 cycle after the 18th beat.
- No response, TIMEOUT_CYCLES=8 → done exactly 8 cycles after RECV entry with no beats, err=1, rsp_len=0, tready=0 afterward.
- cmd_len=0 and cmd_len=17 → done 1 cycle later with err=3 and no tvalid. A cmd_start issued while busy does not restart the transaction.
- Deassert drm_arstn midway through a 4-word send → tvalid=0 and busy=0 immediately, no done pulse. After release a new 1-word transaction completes normally.
